// File: rtl/branch_commit_unit.sv
// branch_commit_unit: commit-side partner of the branch predictor.
// Queues branch outcomes retired at the ROB head, drains one per cycle onto the
// predictor update interface, raises a multi-cycle flush plus a one-cycle fetch
// redirect on a mispredict, and counts committed / mispredicted branches.
//
// Ports
//   clk_in, rst_in (async, active-high), rdy_in (low = freeze)
//   rob_bcu_*        : committed branch (en, pc, pred_taken, taken, target)
//   bcu_rob_full_out : ROB must not commit a branch this cycle
//   bcu_bp_*         : predictor update (en pulse, correct, pc)
//   bcu_flush_out    : pipeline flush
//   bcu_if_*         : fetch redirect (en pulse, pc)
//   bcu_*_cnt_out    : statistics counters
module branch_commit_unit #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_bcu_en_in,
  input  logic [AW-1:0]    rob_bcu_pc_in,
  input  logic             rob_bcu_pred_taken_in,
  input  logic             rob_bcu_taken_in,
  input  logic [AW-1:0]    rob_bcu_target_in,
  output logic             bcu_rob_full_out,
  output logic             bcu_bp_en_out,
  output logic             bcu_bp_correct_out,
  output logic [AW-1:0]    bcu_bp_pc_out,
  output logic             bcu_flush_out,
  output logic             bcu_if_en_out,
  output logic [AW-1:0]    bcu_if_pc_out,
  output logic [CNT_W-1:0] bcu_branch_cnt_out,
  output logic [CNT_W-1:0] bcu_miss_cnt_out
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [PW:0]    FifoFull  = (PW + 1)'(DEPTH);
  localparam logic [FCW-1:0] FlushInit = FCW'(FLUSH_CYCLES);

  typedef enum logic {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
  logic              if_en_q, if_en_d;
  logic [AW-1:0]     if_pc_q, if_pc_d;

  // FIFO entry: {correct, pc}
  logic [AW:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;

  logic              bp_en_q, bp_correct_q;
  logic [AW-1:0]     bp_pc_q;
  logic [CNT_W-1:0]  branch_cnt_q, miss_cnt_q;

  logic              full, empty, accept, push, pop, bypass, mispredict;
  logic [AW-1:0]     redirect;
  logic [AW:0]       head;

  assign full       = (cnt_q == FifoFull) || (state_q == StFlush);
  assign empty      = (cnt_q == '0);
  assign accept     = rob_bcu_en_in && !full && rdy_in;
  assign mispredict = (rob_bcu_pred_taken_in != rob_bcu_taken_in);
  assign pop        = rdy_in && !empty;
  // An accept into an empty FIFO goes straight to the update registers.
  assign bypass     = accept && empty;
  assign push       = accept && !empty;
  assign redirect   = rob_bcu_taken_in ? rob_bcu_target_in : rob_bcu_pc_in + AW'(4);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if_en_d     = 1'b0;
    if_pc_d     = if_pc_q;
    unique case (state_q)
      StIdle: begin
        if (accept && mispredict) begin
          state_d     = StFlush;
          flush_cnt_d = FlushInit;
          if_en_d     = 1'b1;
          if_pc_d     = redirect;
        end
      end
      StFlush: begin
        if (rdy_in) begin
          if (flush_cnt_q == FCW'(1)) state_d = StIdle;
          else                        flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      if_en_q     <= 1'b0;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if_en_q     <= if_en_d;
      if_pc_q     <= if_pc_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {(rob_bcu_pred_taken_in == rob_bcu_taken_in), rob_bcu_pc_in};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      bp_en_q      <= 1'b0;
      bp_correct_q <= 1'b0;
      bp_pc_q      <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      bp_en_q <= pop || bypass;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PW'(1);
        bp_correct_q <= head[AW];
        bp_pc_q      <= head[AW-1:0];
      end else if (bypass) begin
        bp_correct_q <= !mispredict;
        bp_pc_q      <= rob_bcu_pc_in;
      end
      if (push && !pop)      cnt_q <= cnt_q + (PW + 1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW + 1)'(1);
      if (accept) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (mispredict) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Pulses are suppressed in a frozen cycle.
  assign bcu_rob_full_out   = full;
  assign bcu_bp_en_out      = bp_en_q && rdy_in;
  assign bcu_bp_correct_out = bp_correct_q;
  assign bcu_bp_pc_out      = bp_pc_q;
  assign bcu_flush_out      = (state_q == StFlush);
  assign bcu_if_en_out      = if_en_q && rdy_in;
  assign bcu_if_pc_out      = if_pc_q;
  assign bcu_branch_cnt_out = branch_cnt_q;
  assign bcu_miss_cnt_out   = miss_cnt_q;

endmodule

// File: tb/tb_branch_commit_unit.sv
module tb_branch_commit_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLUSH = 2;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b0;
  logic             en = 1'b0;
  logic [AW-1:0]    pc = '0;
  logic             pt = 1'b0;
  logic             tk = 1'b0;
  logic [AW-1:0]    tgt = '0;
  logic             full, bp_en, bp_correct, flush, if_en;
  logic [AW-1:0]    bp_pc, if_pc;
  logic [CNT_W-1:0] bcnt, mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of pending {correct, pc} plus expected output state.
  logic [AW:0]      mq[$];
  int               m_flush_left;
  logic             m_bp_en, m_bp_correct, m_if_en;
  logic [AW-1:0]    m_bp_pc, m_if_pc;
  logic [CNT_W-1:0] m_bcnt, m_mcnt;

  branch_commit_unit #(.AW(AW), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .rob_bcu_en_in(en), .rob_bcu_pc_in(pc), .rob_bcu_pred_taken_in(pt),
    .rob_bcu_taken_in(tk), .rob_bcu_target_in(tgt),
    .bcu_rob_full_out(full), .bcu_bp_en_out(bp_en), .bcu_bp_correct_out(bp_correct),
    .bcu_bp_pc_out(bp_pc), .bcu_flush_out(flush), .bcu_if_en_out(if_en),
    .bcu_if_pc_out(if_pc), .bcu_branch_cnt_out(bcnt), .bcu_miss_cnt_out(mcnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush_left = 0;
    m_bp_en = 1'b0; m_bp_correct = 1'b0; m_bp_pc = '0;
    m_if_en = 1'b0; m_if_pc = '0;
    m_bcnt = '0; m_mcnt = '0;
  endtask

  task automatic check_all();
    chk("full",       64'(full),       64'((mq.size() == DEPTH) || (m_flush_left > 0)));
    chk("bp_en",      64'(bp_en),      64'(m_bp_en && rdy));
    chk("bp_correct", 64'(bp_correct), 64'(m_bp_correct));
    chk("bp_pc",      64'(bp_pc),      64'(m_bp_pc));
    chk("flush",      64'(flush),      64'(m_flush_left > 0));
    chk("if_en",      64'(if_en),      64'(m_if_en && rdy));
    chk("if_pc",      64'(if_pc),      64'(m_if_pc));
    chk("branch_cnt", 64'(bcnt),       64'(m_bcnt));
    chk("miss_cnt",   64'(mcnt),       64'(m_mcnt));
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    logic        acc;
    logic [AW:0] e;
    logic [AW-1:0] seq_pc;
    acc = en && rdy && !((mq.size() == DEPTH) || (m_flush_left > 0));
    m_bp_en = 1'b0;
    m_if_en = 1'b0;
    if (rdy) begin
      if (m_flush_left > 0) m_flush_left--;
      if (acc) begin
        mq.push_back({pt == tk, pc});
        m_bcnt = m_bcnt + 1;
        if (pt != tk) begin
          m_mcnt = m_mcnt + 1;
          m_flush_left = FLUSH;
          m_if_en = 1'b1;
          seq_pc = pc + 32'd4;
          m_if_pc = tk ? tgt : seq_pc;
        end
      end
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_bp_en = 1'b1;
        m_bp_correct = e[AW];
        m_bp_pc = e[AW-1:0];
      end
    end
  endtask

  // One cycle: drive inputs, check at the falling edge, then cross the rising edge.
  task automatic cyc(input logic e_i, input logic [AW-1:0] pc_i, input logic pt_i,
                     input logic tk_i, input logic [AW-1:0] tgt_i, input logic rdy_i);
    en = e_i; pc = pc_i; pt = pt_i; tk = tk_i; tgt = tgt_i; rdy = rdy_i;
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // Single correct branch: update on the following cycle.
    cyc(1'b1, 32'h100, 1'b1, 1'b1, 32'h0, 1'b1);
    en = 1'b0;
    chk("dir_bp_en", 64'(bp_en), 64'd1);
    chk("dir_bp_pc", 64'(bp_pc), 64'h100);
    chk("dir_bp_correct", 64'(bp_correct), 64'd1);
    chk("dir_bcnt", 64'(bcnt), 64'd1);
    idle(1);

    // Mispredict, not taken: redirect to pc+4, flush for two cycles.
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 32'h999, 1'b1);
    en = 1'b0;
    chk("mp_if_en", 64'(if_en), 64'd1);
    chk("mp_if_pc", 64'(if_pc), 64'h204);
    chk("mp_flush1", 64'(flush), 64'd1);
    chk("mp_correct", 64'(bp_correct), 64'd0);
    chk("mp_miss", 64'(mcnt), 64'd1);
    // A commit offered during flush is refused.
    cyc(1'b1, 32'h300, 1'b1, 1'b1, 32'h0, 1'b1);
    en = 1'b0;
    chk("mp_flush2", 64'(flush), 64'd1);
    chk("mp_if_en2", 64'(if_en), 64'd0);
    idle(1);
    chk("mp_flush_end", 64'(flush), 64'd0);
    chk("mp_bcnt", 64'(bcnt), 64'd2);

    // Address-space wrap cases.
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h40, 1'b1);
    chk("wrap_taken", 64'(if_pc), 64'h40);
    idle(2);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h40, 1'b1);
    chk("wrap_nt", 64'(if_pc), 64'h0);
    idle(2);

    // Back-to-back commits drain in order, then a frozen stretch.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 1'b1, '0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h2000, 1'b1, 1'b0, '0, 1'b0);
    chk("frz_bcnt", 64'(bcnt), 64'd9);
    idle(2);

    // Asynchronous reset in the middle of a flush.
    cyc(1'b1, 32'h500, 1'b0, 1'b1, 32'h800, 1'b1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_bp_pc", 64'(bp_pc), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_cnt", 64'({bcnt, mcnt}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 9) < 6, rpc, 1'($urandom()), 1'($urandom()),
          $urandom(), $urandom_range(0, 9) < 8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
